// File: rtl/inv_mix_columns_seq_if.sv
// Valid/ready handshake bundle for the sequential InvMixColumns engine:
// 128-bit state in, 128-bit result out.
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport slave (
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );

  modport master (
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns, one 32-bit column per cycle through a shared column datapath.
// Optional AES_IMC_BYPASS_EN adds a bypass port that copies columns unchanged.
module inv_mix_columns_seq (
  input  logic                 clk,
  input  logic                 rst,
`ifdef AES_IMC_BYPASS_EN
  input  logic                 bypass,
`endif
  inv_mix_columns_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    gf_mul9 = xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    gf_mul11 = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    gf_mul13 = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    gf_mul14 = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  state_e       state_q, state_d;
  logic [127:0] src_q, src_d;
  logic [127:0] dst_q, dst_d;
  logic [1:0]   col_q, col_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         byp_q, byp_d;
  logic         byp_in_s;

  logic [31:0]  col_in_s;
  logic [31:0]  col_mix_s;
  logic [31:0]  col_res_s;
  logic [7:0]   a_s   [4];
  logic [7:0]   m9_s  [4];
  logic [7:0]   m11_s [4];
  logic [7:0]   m13_s [4];
  logic [7:0]   m14_s [4];

`ifdef AES_IMC_BYPASS_EN
  assign byp_in_s = bypass;
`else
  assign byp_in_s = 1'b0;
`endif

  // Column mux: select the source column addressed by the counter.
  always_comb begin
    col_in_s = 32'h0000_0000;
    case (col_q)
      2'd0:    col_in_s = src_q[127:96];
      2'd1:    col_in_s = src_q[95:64];
      2'd2:    col_in_s = src_q[63:32];
      2'd3:    col_in_s = src_q[31:0];
      default: col_in_s = 32'h0000_0000;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lut
    assign a_s[i]   = col_in_s[31-8*i -: 8];
    assign m9_s[i]  = gf_mul9(a_s[i]);
    assign m11_s[i] = gf_mul11(a_s[i]);
    assign m13_s[i] = gf_mul13(a_s[i]);
    assign m14_s[i] = gf_mul14(a_s[i]);
  end

  assign col_mix_s = {m14_s[0] ^ m11_s[1] ^ m13_s[2] ^ m9_s[3],
                      m9_s[0]  ^ m14_s[1] ^ m11_s[2] ^ m13_s[3],
                      m13_s[0] ^ m9_s[1]  ^ m14_s[2] ^ m11_s[3],
                      m11_s[0] ^ m13_s[1] ^ m9_s[2]  ^ m14_s[3]};

  assign col_res_s = byp_q ? col_in_s : col_mix_s;

  // Next-state, capture and column write-back.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    col_d   = col_q;
    byp_d   = byp_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_BUSY;
          src_d   = bus.in_state;
          col_d   = 2'd0;
          byp_d   = byp_in_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        case (col_q)
          2'd0:    dst_d[127:96] = col_res_s;
          2'd1:    dst_d[95:64]  = col_res_s;
          2'd2:    dst_d[63:32]  = col_res_s;
          2'd3:    dst_d[31:0]   = col_res_s;
          default: dst_d         = dst_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; handshake flags follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= 128'd0;
      dst_q       <= 128'd0;
      col_q       <= 2'd0;
      byp_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      col_q       <= col_d;
      byp_q       <= byp_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = dst_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: a GF(2^8) matrix reference model,
// a driver that queues expected results on accept, and an independent monitor.
module tb_inv_mix_columns_seq;

  logic clk = 1'b0;
  logic rst;
  logic bypass;
  always #5 clk = ~clk;

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .clk    (clk),
    .rst    (rst),
`ifdef AES_IMC_BYPASS_EN
    .bypass (bypass),
`endif
    .bus    (bus)
  );

  localparam logic [127:0] KV = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] KE = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  typedef struct {
    logic [127:0] exp;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Shift-and-add multiply in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Inverse matrix is circulant with first row {14,11,13,9}.
  function automatic logic [127:0] model_imc(input logic [127:0] st);
    logic [7:0]   coef [4];
    logic [7:0]   r;
    logic [127:0] res = 128'd0;
    coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r = 8'h00;
        for (int k = 0; k < 4; k++)
          r = r ^ gmul(coef[(k - row) & 3], st[127 - 8*(4*c + k) -: 8]);
        res[127 - 8*(4*c + row) -: 8] = r;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] expect_of(input logic [127:0] st, input logic byp);
`ifdef AES_IMC_BYPASS_EN
    return byp ? st : model_imc(st);
`else
    return model_imc(st);
`endif
  endfunction

  // Monitor: checks latency and data on out_valid rise, stability while held.
  initial begin
    logic         prev_ov = 1'b0;
    logic [127:0] held = 128'd0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h, expected no output", bus.out_state);
        end else begin
          check("latency", 128'(cyc), 128'(sb[0].acc + 5));
          check("result", bus.out_state, sb[0].exp);
        end
        held = bus.out_state;
      end else if (bus.out_valid) begin
        check("hold", bus.out_state, held);
      end
      if (bus.out_valid) check("in_ready_low", 128'(bus.in_ready), 128'd0);
      if (bus.out_valid && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      prev_ov = bus.out_valid;
    end
  end

  task automatic issue(input logic [127:0] st, input logic [127:0] exp, input logic byp);
    bit ok = 1'b0;
    bus.in_state = st;
    bus.in_valid = 1'b1;
    bypass       = byp;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{exp, cyc});
        acc_log.push_back(cyc);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_state = {$urandom, $urandom, $urandom, $urandom};
    bypass       = ~byp;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [127:0] v;
    rst          = 1'b1;
    bypass       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_state = 128'd0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_state", bus.out_state, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known vector, consumer always ready
    issue(KV, KE, 1'b0);
    drain();

    // Back-pressure with an ignored second request
    bus.out_ready = 1'b0;
    issue(KV, KE, 1'b0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
    check("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    check("bp_queue_empty", 128'(sb.size()), 128'd0);

    // Back-to-back throughput
    acc_log.delete();
    issue(KV, KE, 1'b0);
    issue(128'd0, 128'd0, 1'b0);
    drain();
    check("b2b_spacing", 128'(acc_log[1] - acc_log[0]), 128'd6);

    // Reset two cycles after accept
    issue(KV, KE, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("mid_rst_out_state", bus.out_state, 128'd0);
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    v = {$urandom, $urandom, $urandom, $urandom};
    issue(v, model_imc(v), 1'b0);
    drain();

    // Fixed points
    issue({4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, 1'b0);
    issue({4{32'h01010101}}, {4{32'h01010101}}, 1'b0);
    drain();

    // Randomised vectors with random consumer stalls
    for (int n = 0; n < 20; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = 1'($urandom_range(0, 1));
      issue(v, expect_of(v, 1'b0), 1'b0);
      repeat ($urandom_range(3, 9)) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();
    end

`ifdef AES_IMC_BYPASS_EN
    issue(KV, KV, 1'b1);
    drain();
    issue(KV, KE, 1'b0);
    drain();
    for (int n = 0; n < 6; n++) begin
      logic b;
      v = {$urandom, $urandom, $urandom, $urandom};
      b = 1'($urandom_range(0, 1));
      issue(v, expect_of(v, b), b);
      drain();
    end
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
